addsub_seq_ctrl: RTL and testbench
==================================

# addsub_seq_ctrl

Sequencing controller that performs a WIDTH = 4×NIBBLES-bit add or subtract by time-multiplexing one 4-bit ripple add/sub slice over the operand nibbles, LSB nibble first. It carries the inter-nibble carry in a register, assembles the result, and reports carry-out and signed overflow. It sits between the processor control unit, which issues start/op, and the register-file operands, and provides a wide ALU operation at the area cost of a single slice.

## Interface
- NIBBLES, default 4: number of 4-bit nibbles; WIDTH = 4×NIBBLES; legal range 2..16.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  1  0 = A+B, 1 = A−B; latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- abort  in  1  present only with ADDSUB_SEQ_ABORT_EN.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  last completed sum/difference; held between completions.
- cout  out  1  final carry-out. For subtract, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow of the last operation.

## Operation
- Internal instance: one 4-bit add/sub slice with inputs A4, B4, Ci and outputs S4, Co. The slice inverts B4 internally when Ci=1, so subtraction is driven by op.
- Slice Ci = carry register on nibble 0 and on later nibbles. The slice's B inversion must follow op on every nibble, not Ci. Therefore feed the slice B4 ^ {4{op}} ^ {4{carry}} on nibbles 1..N−1, or use an equivalent arrangement, so that the effective operand is always b_nibble ^ {4{op}}.
- FSM states:
  - IDLE → RUN on start=1.
  - RUN → DONE on the edge that processes nibble NIBBLES−1.
  - DONE → RUN if start=1, otherwise → IDLE.
- On accept: latch a, b, op; set idx=0; set carry=op.
- Each RUN edge:
  - work[4·idx+:4] ← S4.
  - carry ← Co.
  - idx ← idx+1.
- Final RUN edge:
  - result ← work with the top nibble replaced by S4.
  - cout ← Co.
  - ovf ← (a_msb == beff_msb) && (S4[3] != a_msb), where beff_msb = b_msb ^ op.
- start while in RUN is ignored and not queued.
- Operand inputs may change freely after the accept edge.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, cout 0, ovf 0, idx 0, carry 0.
- Accept at edge k. busy is high in the cycles after edges k..k+NIBBLES−1.
- done is high for exactly the one cycle after edge k+NIBBLES, together with the new result, cout and ovf. Latency from accept to done is NIBBLES+1 edges.
- Back-to-back: start high during DONE is accepted. busy rises the next cycle, giving a throughput of one operation per NIBBLES+1 cycles.
- result, cout and ovf change only on a final RUN edge and never during RUN.
- Reset asserted mid-operation: all state returns to reset values immediately. No done is produced, and the prior result is lost (cleared to 0).
- idx wraps to 0 on the transition to DONE. No out-of-range nibble access occurs.

## Configuration
- ADDSUB_SEQ_ABORT_EN defined:
  - abort port exists.
  - abort=1 in RUN forces IDLE at the next edge: busy→0, no done pulse, result/cout/ovf unchanged.
  - abort outside RUN has no effect.
  - abort has priority over the final-nibble transition.
- ADDSUB_SEQ_ABORT_EN undefined: no abort port; RUN always completes.

## Test plan
- NIBBLES=4, add 0x1234 + 0x0FCD → result 0x2201, cout 0, ovf 0. done arrives 5 edges after accept, busy is high for exactly 4 cycles.
- Add 0xFFFF + 0x0001 → result 0x0000, cout 1, ovf 0. Add 0x7FFF + 0x0001 → result 0x8000, cout 0, ovf 1.
- Sub 0x8000 − 0x0001 → result 0x7FFF, cout 1, ovf 1. Sub 0x0000 − 0x0001 → result 0xFFFF, cout 0, ovf 0.
- start pulsed in the 2nd RUN cycle with different operands → ignored, first result intact. Then start during DONE → back-to-back operation completes correctly.
- rst_n pulsed low in the 3rd RUN cycle → all outputs 0 immediately, no done. A subsequent operation is correct.
- With ADDSUB_SEQ_ABORT_EN: abort in the 2nd RUN cycle → IDLE, no done, result still holds the previous value. Without the macro: the build has no abort port.

Source files
------------

// File: rtl/addsub_seq_ctrl.sv
// -----------------------------------------------------------------------------
// addsub_seq_ctrl
//
// Computes a WIDTH = 4*NIBBLES bit add or subtract using a single 4-bit
// add/sub slice. The slice is applied to one operand nibble per cycle, LSB
// nibble first. The inter-nibble carry is kept in a register, and the final
// edge publishes the result, carry-out and signed overflow.
//
// Optional feature macro:
//   ADDSUB_SEQ_ABORT_EN - adds the 'abort' input. It cancels an operation
//                         that is in progress. When undefined, the port is
//                         absent and every operation runs to completion.
//
// Parameters:
//   NIBBLES  number of 4-bit nibbles (2..16), WIDTH = 4*NIBBLES
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request, sampled only in IDLE or DONE
//   op      in   0 = a+b, 1 = a-b (latched with start)
//   a, b    in   WIDTH-bit operands (latched with start)
//   abort   in   cancel operation in RUN (ADDSUB_SEQ_ABORT_EN only)
//   busy    out  high while nibbles are being processed
//   done    out  one-cycle completion pulse
//   result  out  last completed sum/difference, held between completions
//   cout    out  final carry-out (subtract: 1 = no borrow)
//   ovf     out  two's-complement overflow of the last operation
// -----------------------------------------------------------------------------

// 4-bit ripple add/sub slice. B is inverted internally whenever ci=1.
module addsub_slice4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       ci,
  output logic [3:0] s4,
  output logic       co
);

  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, a4} + {1'b0, b4 ^ {4{ci}}} + {4'b0000, ci};
    s4  = sum[3:0];
    co  = sum[4];
  end

endmodule

module addsub_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
`ifdef ADDSUB_SEQ_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned WIDTH = 4 * NIBBLES;
  localparam int unsigned IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [WIDTH-1:0]  a_q, b_q, work;
  logic              op_q;
  logic [IW-1:0]     idx;
  logic              carry;

  logic              accept;
  logic              last;
  logic              abort_run;
  logic [3:0]        a_nib, b_nib, slice_b, s4;
  logic              co;

`ifdef ADDSUB_SEQ_ABORT_EN
  assign abort_run = abort && (state == RUN);
`else
  assign abort_run = 1'b0;
`endif

  assign last = (idx == LAST_IDX);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Next-state and accept decode.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort takes priority over the final-nibble transition
        if (abort_run) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the current operand nibbles.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  // The slice inverts B whenever its carry-in is 1, but the inversion must
  // follow op. Pre-XOR with carry cancels the slice's own inversion, so the
  // effective operand is always b_nib ^ {4{op}}. On nibble 0 the carry
  // equals op, so the same expression holds for every nibble.
  assign slice_b = b_nib ^ {4{op_q}} ^ {4{carry}};

  addsub_slice4 u_slice (
    .a4 (a_nib),
    .b4 (slice_b),
    .ci (carry),
    .s4 (s4),
    .co (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      work   <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        idx   <= '0;
        carry <= op;
      end else if (state == RUN) begin
        if (abort_run) begin
          idx <= '0;
        end else begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
              work[4*i +: 4] <= s4;
            end
          end
          carry <= co;
          if (last) begin
            idx    <= '0;
            result <= {s4, work[WIDTH-5:0]};
            cout   <= co;
            ovf    <= (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ op_q)) &&
                      (s4[3] != a_q[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
module tb_addsub_seq_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef ADDSUB_SEQ_ABORT_EN
  logic         abort;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  logic [W-1:0] last_res = '0;

  addsub_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
`ifdef ADDSUB_SEQ_ABORT_EN
    .abort  (abort),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: two's-complement sum with explicit carry and sign rules.
  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    if (!o) s = {1'b0, x} + {1'b0, y};
    else    s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    e.r = s[W-1:0];
    e.c = s[W];
    if (!o) e.v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    else    e.v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    return e;
  endfunction

  // Called at a negedge; the accept edge is the next posedge. Returns at the
  // negedge of the first RUN cycle with operands scrambled.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e, input logic push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op    = 1'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Scans from the current negedge (counted as cycle 1) until done.
  task automatic wait_done(output int lat, output int nbusy);
    logic got;
    exp_t e;
    got   = 1'b0;
    lat   = 0;
    nbusy = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (i > 1) @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = i;
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.r));
          chk("cout", 32'(cout), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.v));
          last_res = e.r;
        end
      end else begin
        if (busy) nbusy++;
        chk("result_held", 32'(result), 32'(last_res));
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 20 cycles, required done");
    end
  endtask

  vec_t vecs[12];

  initial begin
    int   lat, nb;
    logic seen;
    exp_t e;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0};
    for (int i = 8; i < 12; i++) begin
      vecs[i].op = 1'($urandom);
      vecs[i].a  = W'($urandom);
      vecs[i].b  = W'($urandom);
      e = model(vecs[i].op, vecs[i].a, vecs[i].b);
      vecs[i].r = e.r;
      vecs[i].c = e.c;
      vecs[i].v = e.v;
    end

    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
`ifdef ADDSUB_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // Table-driven operations with latency, busy width and pulse width.
    for (int i = 0; i < 12; i++) begin
      e.r = vecs[i].r;
      e.c = vecs[i].c;
      e.v = vecs[i].v;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, e, 1'b1);
      wait_done(lat, nb);
      chk("latency", 32'(lat), 5);
      chk("busy_cycles", 32'(nb), 4);
      @(negedge clk);
      chk("done_width", 32'(done), 0);
    end

    // start in the 2nd RUN cycle is ignored; then back-to-back from DONE.
    e = model(1'b0, 16'h1111, 16'h2222);
    issue(1'b0, 16'h1111, 16'h2222, e, 1'b1);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb);
    chk("ignored_start_latency", 32'(lat), 3);
    e = model(1'b1, 16'h4000, 16'h9001);
    issue(1'b1, 16'h4000, 16'h9001, e, 1'b1);
    chk("b2b_busy_rise", 32'(busy), 1);
    wait_done(lat, nb);
    chk("b2b_latency", 32'(lat), 5);
    chk("b2b_busy_cycles", 32'(nb), 4);
    @(negedge clk);
    chk("b2b_done_width", 32'(done), 0);

    // Reset asserted in the 3rd RUN cycle.
    e = model(1'b0, 16'h0F0F, 16'h0101);
    issue(1'b0, 16'h0F0F, 16'h0101, e, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_cout", 32'(cout), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 0);
    e = model(1'b1, 16'h0100, 16'h0200);
    issue(1'b1, 16'h0100, 16'h0200, e, 1'b1);
    wait_done(lat, nb);
    chk("post_rst_latency", 32'(lat), 5);
    @(negedge clk);

`ifdef ADDSUB_SEQ_ABORT_EN
    // Abort in the 2nd RUN cycle: back to IDLE, no done, result kept.
    e = model(1'b0, 16'h2222, 16'h3333);
    issue(1'b0, 16'h2222, 16'h3333, e, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 0);
    chk("abort_result_held", 32'(result), 32'(last_res));
    // abort outside RUN has no effect on accept
    abort = 1'b1;
    e = model(1'b0, 16'h00FF, 16'h0001);
    issue(1'b0, 16'h00FF, 16'h0001, e, 1'b1);
    abort = 1'b0;
    wait_done(lat, nb);
    chk("post_abort_latency", 32'(lat), 5);
    @(negedge clk);
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
